adder_arbiter: RTL
==================

Name: adder_arbiter

Overview:
- Shares one registered 16-bit half-sum adder between NUM_REQ requesters.
- The adder takes a 32-bit word, adds its upper and lower halves, and has 1-cycle latency, no enable and no stall.
- The arbiter grants requesters round-robin, drives the adder input, tags each operation with the requester ID, and buffers results in an in-order FIFO with valid/ready backpressure.
- Credit-based issue guarantees that no result is ever dropped, even though the adder cannot stall.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- FIFO_DEPTH, 4, result FIFO entries. Also the credit count.
- ID_W, derived localparam = clog2(NUM_REQ), width of the requester tag.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_data  in  NUM_REQ*32  operand i at [32i+31:32i]; upper half a, lower half b.
- req_ready  out  NUM_REQ  grant; at most one bit high.
- adder_in  out  32  to adder input.
- adder_out  in  32  from adder output; only bits [15:0] are used.
- resp_valid  out  1  FIFO head valid.
- resp_id  out  ID_W  requester tag of the head entry.
- resp_sum  out  16  (a+b) mod 2^16 for the head entry.
- resp_ready  in  1  consumer accepts the head entry.
- busy  out  1  high while any operation is in flight or buffered.

Behaviour:
- Reset (async, immediate) clears the following:
  - ptr = NUM_REQ-1, so requester 0 has first priority.
  - credit = FIFO_DEPTH.
  - s1_valid = 0 and s2_valid = 0.
  - FIFO empty.
  - adder_in = 0, resp_valid = 0, resp_id = 0, resp_sum = 0, busy = 0.
  - req_ready is 0 while reset is high.
- The adder's own reset is driven by integration from the same reset source. While s2_valid = 0 the adder output is ignored.
- Arbitration (combinational):
  - Search starts at ptr+1 mod NUM_REQ and picks the first i with req_valid[i] = 1.
  - req_ready[i] = 1 only if credit > 0 (registered value).
  - req_ready depends on req_valid; requesters must not make valid depend on ready.
- Handshake: req_valid[i] & req_ready[i] at a rising edge is a grant.
- On grant:
  - ptr <= i.
  - credit decrements.
  - adder_in <= operand i, s1_valid <= 1, s1_id <= i.
- With no grant, adder_in holds its value and s1_valid <= 0.
- Pipeline:
  - s2_valid <= s1_valid and s2_id <= s1_id, on the same edge at which the adder registers the sum.
  - When s2_valid = 1, FIFO pushes {s2_id, adder_out[15:0]} at the next edge.
  - Carry out of bit 15 is discarded.
- Latency: handshake in cycle c gives resp_valid in cycle c+3 if the FIFO was empty. The output is the registered FIFO head.
- Pop: resp_valid & resp_ready pops the head and increments credit.
  - Grant and pop in the same cycle leave credit unchanged.
  - A popped credit becomes usable the cycle after the pop.
- FIFO:
  - Push and pop in the same cycle are legal.
  - Order is strictly issue order.
  - Overflow is impossible by construction (credits). An assertion must flag a push when the FIFO is full.
- Throughput: with FIFO_DEPTH >= 4 and resp_ready held at 1, one grant per cycle is sustained.
- busy = (credit != FIFO_DEPTH).
- resp_valid low: resp_id and resp_sum hold the last popped value, or 0 after reset.
- Reset mid-operation: all in-flight and buffered results are discarded. No resp_valid follows reset deassertion unless a new grant occurs.

Test Plan:
- Reset, then req_valid[0] = 1 with 0x0003_0004:
  - req_ready[0] = 1 in the same cycle.
  - adder_in = 0x00030004 the next cycle.
  - resp_valid = 1 three cycles after the handshake, with resp_id = 0 and resp_sum = 0x0007.
- Wrap-around:
  - 0xFFFF_0001 gives 0x0000.
  - 0x8000_8000 gives 0x0000.
  - 0xFFFF_FFFF gives 0xFFFE.
  - 0x1234_0000 gives 0x1234.
- All four requesters valid continuously, resp_ready = 1:
  - Grants run 0,1,2,3,0,1... at one per cycle with no bubbles.
  - resp_id follows the same sequence, lagging by 3 cycles.
- resp_ready = 0 with all requesters valid:
  - Exactly 4 grants, then req_ready = 0000 with busy = 1.
  - Raising resp_ready drains the 4 results in order; grants resume in the cycle after the first pop.
- Only requesters 2 and 3 valid, starting from reset: grant sequence is 2,3,2,3 (wrap skips invalid 0 and 1).
- Reset pulsed with 2 operations in flight and 1 buffered:
  - resp_valid and busy drop immediately.
  - No response appears after deassertion.
  - The next grant with requesters 0 and 1 valid goes to 0.

Source files
------------

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one registered half-sum adder between NUM_REQ requesters.
// Results are tagged with the requester ID and returned in issue order through a credit-guarded FIFO.
module adder_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned FIFO_DEPTH = 4,
  localparam int unsigned ID_W      = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*32-1:0]   req_data,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [31:0]             adder_in,
  input  logic [31:0]             adder_out,
  output logic                    resp_valid,
  output logic [ID_W-1:0]         resp_id,
  output logic [15:0]             resp_sum,
  input  logic                    resp_ready,
  output logic                    busy
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CNT_W-1:0] CREDIT_MAX = CNT_W'(FIFO_DEPTH);

  logic [31:0]       ops [NUM_REQ];
  logic [ID_W-1:0]   ptr;
  logic [CNT_W-1:0]  credit;
  logic              s1_valid, s2_valid;
  logic [ID_W-1:0]   s1_id, s2_id;
  logic              gnt_found;
  logic [ID_W-1:0]   gnt_idx;
  logic [ID_W-1:0]   cand;
  logic              grant;
  logic              pop;
  logic              push;
  logic [ID_W+15:0]  push_data;

  logic [ID_W+15:0]  mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr, rd_next;
  logic [CNT_W-1:0]  count, remaining, count_next;
  logic [ID_W+15:0]  head_next;
  logic              unused_hi;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_ops
    assign ops[g] = req_data[32*g +: 32];
  end

  assign unused_hi = ^adder_out[31:16];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Rotating search: first valid requester strictly after the last grant.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((32'(ptr) + k) % NUM_REQ);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  assign grant = gnt_found && (credit != '0) && !reset;

  always_comb begin
    req_ready = '0;
    if (grant) req_ready[gnt_idx] = 1'b1;
  end

  assign pop       = resp_valid && resp_ready;
  assign push      = s2_valid;
  assign push_data = {s2_id, adder_out[15:0]};
  assign busy      = (credit != CREDIT_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr      <= ID_W'(NUM_REQ - 1);
      credit   <= CREDIT_MAX;
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1_id    <= '0;
      s2_id    <= '0;
      adder_in <= '0;
    end else begin
      s1_valid <= grant;
      s2_valid <= s1_valid;
      s2_id    <= s1_id;
      if (grant) begin
        ptr      <= gnt_idx;
        s1_id    <= gnt_idx;
        adder_in <= ops[gnt_idx];
      end
      if (grant && !pop)      credit <= credit - 1'b1;
      else if (!grant && pop) credit <= credit + 1'b1;
    end
  end

  // The head register is loaded with whatever will sit at the head after this edge;
  // when the FIFO drains to empty it keeps the value just popped.
  always_comb begin
    rd_next    = pop ? ptr_inc(rd_ptr) : rd_ptr;
    remaining  = count - CNT_W'(pop);
    count_next = remaining + CNT_W'(push);
    head_next  = (remaining == '0) ? push_data : mem[rd_next];
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_sum   <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      rd_ptr     <= rd_next;
      count      <= count_next;
      resp_valid <= (count_next != '0);
      if (count_next != '0) {resp_id, resp_sum} <= head_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(push && (count == CREDIT_MAX)))
        else $error("adder_arbiter: result pushed into full FIFO");
    end
  end

endmodule
